db_scan_ctrl: RTL and testbench

- Shared, time-multiplexed debounce controller for NUM_CH switch inputs. Replaces one full debouncer per switch.
- One prescaler and one scan pointer visit each channel in turn. A small per-channel integrator decides the stable level.
- Rising-edge events from all channels are arbitrated round-robin onto one valid/ready event port for the downstream consumer (e.g. a UART report or a CSR block).

---
 rtl/db_scan_pkg.sv | 35 +++
 rtl/db_scan_ctrl_arb.sv | 76 +++++++
 rtl/db_scan_ctrl.sv | 132 +++++++++++++
 tb/tb_db_scan_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/db_scan_pkg.sv
// Shared constants and the round-robin pick helper for the time-multiplexed debounce controller.
package db_scan_pkg;

    localparam int NUM_CH_DEF     = 4;
    localparam int SAMPLE_DIV_DEF = 30;
    localparam int STABLE_CNT_DEF = 4;
    localparam int CH_W           = $clog2(NUM_CH_DEF);
    localparam int CNT_W          = $clog2(STABLE_CNT_DEF);
    localparam int MAX_CH         = 16;

    // First set bit of pending at or after rr_ptr, walking circularly over num_ch channels.
    function automatic logic [3:0] rr_pick(input logic [15:0] pending,
                                           input logic [3:0]  rr_ptr,
                                           input logic [4:0]  num_ch);
        logic [3:0] idx;
        logic       found;
        rr_pick = rr_ptr;
        idx     = rr_ptr;
        found   = 1'b0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (!found && (5'(i) < num_ch) && pending[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end else begin
                found = found;
            end
            if ({1'b0, idx} == (num_ch - 5'd1)) begin
                idx = 4'd0;
            end else begin
                idx = idx + 4'd1;
            end
        end
    endfunction

endpackage

// File: rtl/db_scan_ctrl_arb.sv
// Round-robin arbiter: per-channel pending bits feeding one registered valid/ready event port.
module db_rr_arb
    import db_scan_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_CH-1:0]         rise_i,
    output logic                      evt_valid_o,
    output logic [$clog2(NUM_CH)-1:0] evt_ch_o,
    input  logic                      evt_ready_i,
    output logic                      evt_overflow_o
);

    localparam int CHW = $clog2(NUM_CH);

    logic [NUM_CH-1:0] pending_r;
    logic [CHW-1:0]    rr_ptr_r;
    logic              valid_r;
    logic [CHW-1:0]    ch_r;
    logic              overflow_r;

    logic              accept_s;
    logic              load_s;
    logic [CHW-1:0]    sel_s;
    logic [CHW-1:0]    rr_nxt_s;
    logic [NUM_CH-1:0] clr_s;
    logic [NUM_CH-1:0] pend_nxt_s;
    logic              ovf_s;

    // Selection, pending update (a new rise beats a same-cycle clear) and overflow detection.
    always_comb begin
        accept_s = valid_r & evt_ready_i;
        load_s   = (~valid_r | accept_s) & (|pending_r);
        sel_s    = CHW'(rr_pick(16'(pending_r), 4'(rr_ptr_r), 5'(NUM_CH)));
        clr_s    = {NUM_CH{1'b0}};
        rr_nxt_s = rr_ptr_r;
        if (load_s) begin
            clr_s[sel_s] = 1'b1;
            rr_nxt_s     = (sel_s == CHW'(NUM_CH - 1)) ? {CHW{1'b0}} : sel_s + CHW'(1);
        end else begin
            clr_s = {NUM_CH{1'b0}};
        end
        pend_nxt_s = (pending_r & ~clr_s) | rise_i;
        ovf_s      = |(rise_i & pending_r & ~clr_s);
    end

    // Pending bits, rr pointer, sticky overflow and the held output register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_r  <= {NUM_CH{1'b0}};
            rr_ptr_r   <= {CHW{1'b0}};
            valid_r    <= 1'b0;
            ch_r       <= {CHW{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            pending_r  <= pend_nxt_s;
            rr_ptr_r   <= rr_nxt_s;
            overflow_r <= overflow_r | ovf_s;
            if (load_s) begin
                valid_r <= 1'b1;
                ch_r    <= sel_s;
            end else if (accept_s) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

    assign evt_valid_o    = valid_r;
    assign evt_ch_o       = ch_r;
    assign evt_overflow_o = overflow_r;

endmodule

// File: rtl/db_scan_ctrl.sv
// Shared debounce controller: one prescaler and scan pointer service NUM_CH integrators,
// and rising events are funnelled through a round-robin valid/ready port.
module db_scan_ctrl
    import db_scan_pkg::*;
#(
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
    parameter int STABLE_CNT = STABLE_CNT_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_CH-1:0]         sw_i,
    input  logic                      en_i,
    output logic [NUM_CH-1:0]         db_level_o,
    output logic [NUM_CH-1:0]         db_tick_o,
    output logic                      evt_valid_o,
    output logic [$clog2(NUM_CH)-1:0] evt_ch_o,
    input  logic                      evt_ready_i,
    output logic                      evt_overflow_o
);

    localparam int CHW   = $clog2(NUM_CH);
    localparam int CNTW  = $clog2(STABLE_CNT);
    localparam int DIV_W = $clog2(SAMPLE_DIV);

    logic [DIV_W-1:0]  div_r;
    logic [CHW-1:0]    ch_idx_r;
    logic [NUM_CH-1:0] sync1_r;
    logic [NUM_CH-1:0] sync2_r;
    logic [CNTW-1:0]   cnt_r [NUM_CH];
    logic [NUM_CH-1:0] level_r;
    logic [NUM_CH-1:0] tick_r;

    logic              strobe_s;
    logic              sample_s;
    logic              cur_lvl_s;
    logic [CNTW-1:0]   cur_cnt_s;
    logic [CNTW-1:0]   cnt_nxt_s;
    logic              flip_s;
    logic [NUM_CH-1:0] rise_s;

    assign strobe_s = en_i && (div_r == DIV_W'(SAMPLE_DIV - 1));

    // Prescaler and scan pointer; both freeze while en_i is low.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_r    <= {DIV_W{1'b0}};
            ch_idx_r <= {CHW{1'b0}};
        end else if (strobe_s) begin
            div_r    <= {DIV_W{1'b0}};
            ch_idx_r <= (ch_idx_r == CHW'(NUM_CH - 1)) ? {CHW{1'b0}} : ch_idx_r + CHW'(1);
        end else if (en_i) begin
            div_r    <= div_r + DIV_W'(1);
            ch_idx_r <= ch_idx_r;
        end else begin
            div_r    <= div_r;
            ch_idx_r <= ch_idx_r;
        end
    end

    // Two-flop synchronizer on the raw switch inputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_r <= {NUM_CH{1'b0}};
            sync2_r <= {NUM_CH{1'b0}};
        end else begin
            sync1_r <= sw_i;
            sync2_r <= sync1_r;
        end
    end

    // Integrator decision for the channel under the scan pointer.
    always_comb begin
        sample_s  = sync2_r[ch_idx_r];
        cur_lvl_s = level_r[ch_idx_r];
        cur_cnt_s = cnt_r[ch_idx_r];
        cnt_nxt_s = {CNTW{1'b0}};
        flip_s    = 1'b0;
        rise_s    = {NUM_CH{1'b0}};
        if (sample_s == cur_lvl_s) begin
            cnt_nxt_s = {CNTW{1'b0}};
        end else if (cur_cnt_s == CNTW'(STABLE_CNT - 1)) begin
            flip_s = 1'b1;
        end else begin
            cnt_nxt_s = cur_cnt_s + CNTW'(1);
        end
        if (strobe_s && flip_s && !cur_lvl_s) begin
            rise_s[ch_idx_r] = 1'b1;
        end else begin
            rise_s = {NUM_CH{1'b0}};
        end
    end

    // Integrator counters, debounced levels and the rising tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cnt_r[i] <= {CNTW{1'b0}};
            end
            level_r <= {NUM_CH{1'b0}};
            tick_r  <= {NUM_CH{1'b0}};
        end else begin
            tick_r <= rise_s;
            if (strobe_s) begin
                cnt_r[ch_idx_r] <= cnt_nxt_s;
                if (flip_s) begin
                    level_r[ch_idx_r] <= ~cur_lvl_s;
                end else begin
                    level_r <= level_r;
                end
            end else begin
                level_r <= level_r;
            end
        end
    end

    assign db_level_o = level_r;
    assign db_tick_o  = tick_r;

    db_rr_arb #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .rise_i         (rise_s),
        .evt_valid_o    (evt_valid_o),
        .evt_ch_o       (evt_ch_o),
        .evt_ready_i    (evt_ready_i),
        .evt_overflow_o (evt_overflow_o)
    );

endmodule

// File: tb/tb_db_scan_ctrl.sv
// Directed bench for db_scan_ctrl at default parameters (4 channels, 30-cycle slots, 4 samples).
module tb_db_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sw = 4'hF;
    logic       en = 1'b1;
    logic       ready = 1'b0;
    logic [3:0] db_level;
    logic [3:0] db_tick;
    logic       evt_valid;
    logic [1:0] evt_ch;
    logic       evt_overflow;

    int tests = 0;
    int fails = 0;
    int t = 0;
    int tick_cnt [4] = '{0, 0, 0, 0};
    int snap;

    db_scan_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sw_i           (sw),
        .en_i           (en),
        .db_level_o     (db_level),
        .db_tick_o      (db_tick),
        .evt_valid_o    (evt_valid),
        .evt_ch_o       (evt_ch),
        .evt_ready_i    (ready),
        .evt_overflow_o (evt_overflow)
    );

    always #5 clk = ~clk;

    // Count tick pulses per channel.
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (db_tick[i]) tick_cnt[i] <= tick_cnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, stop on the following falling edge.
    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    // Hold reset for two edges, then release with the given switch pattern.
    task automatic do_reset(input logic [3:0] sw_rel);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sw  = sw_rel;
        t   = 0;
    endtask

    task automatic pulse_ready();
        ready = 1'b1;
        @(posedge clk);
        t++;
        @(negedge clk);
        ready = 1'b0;
    endtask

    initial begin
        // Reset with all switches high; ch0 is first to flip, on its 4th slot at edge 390.
        @(negedge clk);
        do_reset(4'hF);
        chk("rst_level", db_level, 4'h0);
        chk("rst_tick", db_tick, 4'h0);
        chk("rst_valid", evt_valid, 1'b0);
        chk("rst_ch", evt_ch, 2'd0);
        chk("rst_ovf", evt_overflow, 1'b0);
        adv(389);
        chk("rst_hold_389", db_level, 4'h0);
        adv(1);
        chk("first_flip_level", db_level, 4'h1);
        chk("first_flip_tick", db_tick, 4'h1);
        adv(1);
        chk("first_evt_valid", evt_valid, 1'b1);
        chk("first_evt_ch", evt_ch, 2'd0);
        chk("first_tick_gone", db_tick, 4'h0);

        // Mid-run reset drops levels and the in-flight event.
        sw = 4'h0;
        do_reset(4'h0);
        chk("midrst_level", db_level, 4'h0);
        chk("midrst_valid", evt_valid, 1'b0);

        // Clean press on ch2: slots at 90/210/330/450.
        do_reset(4'b0100);
        adv(449);
        chk("press_before", db_level, 4'h0);
        snap = tick_cnt[2];
        adv(1);
        chk("press_level", db_level, 4'b0100);
        chk("press_tick", db_tick, 4'b0100);
        adv(1);
        chk("press_tick_1cyc", db_tick, 4'h0);
        chk("press_valid", evt_valid, 1'b1);
        chk("press_ch", evt_ch, 2'd2);
        adv(9);
        chk("press_hold_valid", evt_valid, 1'b1);
        chk("press_hold_ch", evt_ch, 2'd2);
        pulse_ready();
        chk("press_accepted", evt_valid, 1'b0);
        sw = 4'h0;
        adv(500);
        chk("release_level", db_level, 4'h0);
        chk("release_no_tick", tick_cnt[2] - snap, 32'd1);
        chk("release_no_evt", evt_valid, 1'b0);

        // Bounce on ch1: every low gap spans a full revisit period, so the count restarts.
        snap = tick_cnt[1];
        for (int i = 0; i < 10; i++) begin
            sw[1] = 1'b1;
            adv($urandom_range(12, 120));
            sw[1] = 1'b0;
            adv(120);
            chk("bounce_level", db_level[1], 1'b0);
        end
        chk("bounce_ticks", tick_cnt[1] - snap, 32'd0);
        chk("bounce_no_evt", evt_valid, 1'b0);

        // Round-robin: ch0/ch1/ch3 flip at 390/420/480, ready held low.
        do_reset(4'b1011);
        adv(500);
        chk("rr_first_valid", evt_valid, 1'b1);
        chk("rr_first_ch", evt_ch, 2'd0);
        pulse_ready();
        chk("rr_second_valid", evt_valid, 1'b1);
        chk("rr_second_ch", evt_ch, 2'd1);
        pulse_ready();
        chk("rr_third_valid", evt_valid, 1'b1);
        chk("rr_third_ch", evt_ch, 2'd3);
        pulse_ready();
        chk("rr_drained", evt_valid, 1'b0);

        // Second pass: ch0 presented (pointer now 1), then ch3 and ch0 both pending behind it.
        sw = 4'b0010;
        adv(500);
        chk("rr2_levels_low", db_level, 4'b0010);
        sw = 4'b0011;
        adv(500);
        chk("rr2_hold_ch", evt_ch, 2'd0);
        sw = 4'b1010;
        adv(500);
        sw = 4'b1011;
        adv(500);
        chk("rr2_levels", db_level, 4'b1011);
        chk("rr2_still_ch0", evt_ch, 2'd0);
        pulse_ready();
        chk("rr2_next_ch3", evt_ch, 2'd3);
        pulse_ready();
        chk("rr2_next_valid", evt_valid, 1'b1);
        chk("rr2_next_ch0", evt_ch, 2'd0);
        pulse_ready();
        chk("rr2_drained", evt_valid, 1'b0);
        chk("rr2_no_ovf", evt_overflow, 1'b0);

        // Overflow: output busy with ch2, ch0 rises twice while still pending.
        sw = 4'b1111;
        adv(500);
        chk("ovf_busy_ch2", evt_ch, 2'd2);
        snap = tick_cnt[0];
        sw = 4'b1110;
        adv(500);
        sw = 4'b1111;
        adv(500);
        chk("ovf_not_yet", evt_overflow, 1'b0);
        sw = 4'b1110;
        adv(500);
        sw = 4'b1111;
        adv(500);
        chk("ovf_set", evt_overflow, 1'b1);
        chk("ovf_ticks", tick_cnt[0] - snap, 32'd2);
        chk("ovf_still_ch2", evt_ch, 2'd2);
        pulse_ready();
        chk("ovf_ch0_valid", evt_valid, 1'b1);
        chk("ovf_ch0_ch", evt_ch, 2'd0);
        pulse_ready();
        chk("ovf_one_ch0", evt_valid, 1'b0);
        chk("ovf_sticky", evt_overflow, 1'b1);

        // Scan enable: freeze at edge 100 for 1000 edges; ch0 then flips at enabled edge 510.
        do_reset(4'h0);
        chk("en_ovf_cleared", evt_overflow, 1'b0);
        adv(100);
        en = 1'b0;
        sw = 4'b0001;
        adv(1000);
        chk("en_off_level", db_level, 4'h0);
        en = 1'b1;
        adv(409);
        chk("en_resume_before", db_level, 4'h0);
        adv(1);
        chk("en_resume_flip", db_level, 4'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
